// File: rtl/step_pulse_gen.sv
// Synthetic step source: evenly spaced one-cycle step pulses at a mode-selected
// rate, a one-second timebase tick, and the pulse tally of the last second.
// The rate is only reloaded on second boundaries, so each completed second
// holds exactly the scheduled number of pulses.
module step_pulse_gen #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mode,
    output logic        step_pulse,
    output logic        sec_tick,
    output logic [7:0]  steps_last_sec,
    output logic [15:0] elapsed_sec,
    output logic        running
);

    typedef enum logic {
        IDLE,
        RUN
    } stateT;

    stateT       state;
    logic [31:0] acc;        // phase accumulator, always below CLK_HZ
    logic [31:0] cycleCnt;   // RUN cycles already completed in this second
    logic [7:0]  rate;       // steps per second latched for this second
    logic [7:0]  tally;      // pulses issued so far in this second

    logic [31:0] accSum;
    logic        pulseNow;
    logic        lastCycle;
    logic [15:0] elapsedNext;

    // Hybrid schedule, indexed by the seconds count at load time.
    function automatic logic [7:0] hybridRate(input logic [15:0] s);
        logic [7:0] r;
        r = 8'd0;
        if (s <= 16'd8) begin
            case (s[3:0])
                4'd0:    r = 8'd20;
                4'd1:    r = 8'd33;
                4'd2:    r = 8'd66;
                4'd3:    r = 8'd27;
                4'd4:    r = 8'd70;
                4'd5:    r = 8'd30;
                4'd6:    r = 8'd19;
                4'd7:    r = 8'd30;
                default: r = 8'd33;
            endcase
        end else if (s <= 16'd72) begin
            r = 8'd69;
        end else if (s <= 16'd78) begin
            r = 8'd34;
        end else if (s <= 16'd143) begin
            r = 8'd124;
        end
        return r;
    endfunction

    function automatic logic [7:0] rateFor(input logic [1:0] m, input logic [15:0] s);
        logic [7:0] r;
        case (m)
            2'd0:    r = 8'd32;
            2'd1:    r = 8'd64;
            2'd2:    r = 8'd128;
            default: r = hybridRate(s);
        endcase
        return r;
    endfunction

    assign accSum      = acc + {24'd0, rate};
    assign pulseNow    = (accSum >= CLK_HZ);
    assign lastCycle   = (cycleCnt == 32'(CLK_HZ - 1));
    assign elapsedNext = (elapsed_sec == 16'hFFFF) ? elapsed_sec : elapsed_sec + 16'd1;

    // IDLE/RUN control, phase accumulation and second bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: reset and a low start share one clearing path, so a mid-run
        // reset and a start drop leave identical state behind.
        if (reset || !start) begin
            state          <= IDLE;
            acc            <= '0;
            cycleCnt       <= '0;
            rate           <= '0;
            tally          <= '0;
            step_pulse     <= 1'b0;
            sec_tick       <= 1'b0;
            steps_last_sec <= '0;
            elapsed_sec    <= '0;
            running        <= 1'b0;
        end else if (state == IDLE) begin
            state   <= RUN;
            running <= 1'b1;
            rate    <= rateFor(mode, 16'd0);
        end else begin
            step_pulse <= pulseNow;
            if (lastCycle) begin
                // Closing edge of the second: the pulse on this edge still
                // belongs to the ending second.
                sec_tick       <= 1'b1;
                steps_last_sec <= tally + 8'(pulseNow);
                tally          <= '0;
                elapsed_sec    <= elapsedNext;
                rate           <= rateFor(mode, elapsedNext);
                acc            <= '0;
                cycleCnt       <= '0;
            end else begin
                sec_tick <= 1'b0;
                tally    <= tally + 8'(pulseNow);
                cycleCnt <= cycleCnt + 32'd1;
                acc      <= pulseNow ? accSum - 32'(CLK_HZ) : accSum;
            end
        end
    end

    // The latched rate must stay below CLK_HZ or the accumulator overruns.
    always_ff @(posedge clk) begin
        if (!reset && state == RUN) begin
            assert (32'(rate) < CLK_HZ);
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: a vector table for reset, fixed-rate
// timing and mode switching, plus hand sequences for pulse spacing, start
// drop, elapsed saturation and the full hybrid schedule.
module tb_step_pulse_gen;

    logic clk;

    // Instance A runs at 1000 cycles/s; instance B at 200 cycles/s so the
    // 150-second hybrid schedule stays short.
    logic        resetA, startA;
    logic [1:0]  modeA;
    logic        stepA, tickA, runA;
    logic [7:0]  stepsA;
    logic [15:0] elA;

    logic        resetB, startB;
    logic [1:0]  modeB;
    logic        stepB, tickB, runB;
    logic [7:0]  stepsB;
    logic [15:0] elB;

    int errors = 0;
    int checks = 0;

    step_pulse_gen #(.CLK_HZ(1000)) dutA (
        .clk(clk), .reset(resetA), .start(startA), .mode(modeA),
        .step_pulse(stepA), .sec_tick(tickA), .steps_last_sec(stepsA),
        .elapsed_sec(elA), .running(runA)
    );

    step_pulse_gen #(.CLK_HZ(200)) dutB (
        .clk(clk), .reset(resetB), .start(startB), .mode(modeB),
        .step_pulse(stepB), .sec_tick(tickB), .steps_last_sec(stepsB),
        .elapsed_sec(elB), .running(runB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        st;
        logic [1:0]  md;
        int          reps;
        logic        step;
        logic        tck;
        logic        run;
        logic [7:0]  steps;
        logic [15:0] el;
    } vecT;

    vecT vecs[$];

    task automatic addVec(input logic rst, input logic st, input logic [1:0] md, input int reps,
                          input logic step, input logic tck, input logic run,
                          input logic [7:0] steps, input logic [15:0] el);
        vecT v;
        v.rst = rst; v.st = st; v.md = md; v.reps = reps;
        v.step = step; v.tck = tck; v.run = run; v.steps = steps; v.el = el;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge; outputs are read and inputs driven 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int expHybrid(input int s);
        int early [9] = '{20, 33, 66, 27, 70, 30, 19, 30, 33};
        if (s <= 8)   return early[s];
        if (s <= 72)  return 69;
        if (s <= 78)  return 34;
        if (s <= 143) return 124;
        return 0;
    endfunction

    initial begin
        int cnt, mism, ticks;
        logic expStep;

        resetA = 1'b1; startA = 1'b1; modeA = 2'd0;
        resetB = 1'b1; startB = 1'b0; modeB = 2'd3;

        //      rst st md reps  step tck run steps el
        addVec(1, 1, 0, 1,    0, 0, 0, 0,   0);
        addVec(1, 1, 0, 1,    0, 0, 0, 0,   0);
        addVec(0, 1, 0, 1,    0, 0, 1, 0,   0);
        addVec(0, 1, 0, 31,   0, 0, 1, 0,   0);
        addVec(0, 1, 0, 1,    1, 0, 1, 0,   0);   // cycle 32: first walk pulse
        addVec(0, 1, 0, 1,    0, 0, 1, 0,   0);
        addVec(0, 1, 0, 29,   0, 0, 1, 0,   0);
        addVec(0, 1, 0, 1,    1, 0, 1, 0,   0);   // cycle 63: second pulse
        addVec(0, 1, 0, 936,  0, 0, 1, 0,   0);   // cycle 999
        addVec(0, 1, 0, 1,    1, 1, 1, 32,  1);   // cycle 1000: pulse + tick
        addVec(0, 1, 0, 1000, 1, 1, 1, 32,  2);
        addVec(0, 1, 0, 1000, 1, 1, 1, 32,  3);
        addVec(0, 0, 0, 1,    0, 0, 0, 0,   0);   // start drop clears all
        addVec(0, 1, 2, 1,    0, 0, 1, 0,   0);
        addVec(0, 1, 2, 7,    0, 0, 1, 0,   0);
        addVec(0, 1, 2, 1,    1, 0, 1, 0,   0);   // cycle 8: first run pulse
        addVec(0, 1, 2, 491,  0, 0, 1, 0,   0);   // cycle 499
        addVec(0, 1, 1, 501,  1, 1, 1, 128, 1);   // mode change waits a second
        addVec(0, 1, 1, 1000, 1, 1, 1, 64,  2);
        addVec(0, 1, 1, 1,    0, 0, 1, 64,  2);
        addVec(1, 1, 1, 1,    0, 0, 0, 0,   0);   // mid-run reset
        addVec(0, 0, 1, 1,    0, 0, 0, 0,   0);

        foreach (vecs[i]) begin
            resetA = vecs[i].rst;
            startA = vecs[i].st;
            modeA  = vecs[i].md;
            repeat (vecs[i].reps) tick();
            check($sformatf("vec%0d outs", i),
                  {5'd0, stepA, tickA, runA, stepsA, elA},
                  {5'd0, vecs[i].step, vecs[i].tck, vecs[i].run, vecs[i].steps, vecs[i].el});
        end

        // Pulse spacing in jog mode against floor(c*r/CLK) stepping.
        startA = 1'b1; modeA = 2'd1;
        tick();
        check("jog running", 32'(runA), 32'd1);
        for (int sec = 0; sec < 2; sec++) begin
            cnt = 0; mism = 0; ticks = 0;
            for (int c = 1; c <= 1000; c++) begin
                tick();
                expStep = ((c * 64) / 1000) != (((c - 1) * 64) / 1000);
                if (stepA !== expStep) mism++;
                if (tickA !== (c == 1000)) mism++;
                cnt += int'(stepA);
            end
            check($sformatf("jog s%0d timing mismatches", sec), 32'(mism), 32'd0);
            check($sformatf("jog s%0d pulse count", sec), 32'(cnt), 32'd64);
        end

        // Start drop mid-second in hybrid mode, then restart from s = 0.
        startA = 1'b0; tick();
        startA = 1'b1; modeA = 2'd3; tick();
        repeat (1000) tick();
        check("hyb drop s0 steps", {23'd0, tickA, stepsA}, {23'd0, 1'b1, 8'd20});
        repeat (1000) tick();
        check("hyb drop s1 steps", {23'd0, tickA, stepsA}, {23'd0, 1'b1, 8'd33});
        ticks = 0;
        repeat (699) begin
            tick();
            ticks += int'(tickA);
        end
        startA = 1'b0; tick();
        ticks += int'(tickA);
        check("partial second ticks", 32'(ticks), 32'd0);
        check("drop outs cleared", {5'd0, stepA, tickA, runA, stepsA, elA}, 32'd0);
        startA = 1'b1; tick();
        repeat (1000) tick();
        check("restart s0 steps", {7'd0, tickA, stepsA, elA}, {7'd0, 1'b1, 8'd20, 16'd1});

        // Elapsed-seconds saturation.
        startA = 1'b0; tick();
        startA = 1'b1; modeA = 2'd0; tick();
        tick();
        force dutA.elapsed_sec = 16'd65534;
        tick();
        release dutA.elapsed_sec;
        check("forced elapsed", 32'(elA), 32'd65534);
        repeat (998) tick();
        check("sat tick1", {15'd0, tickA, elA}, {15'd0, 1'b1, 16'd65535});
        repeat (1000) tick();
        check("sat tick2", {15'd0, tickA, elA}, {15'd0, 1'b1, 16'd65535});
        startA = 1'b0; tick();

        // Full hybrid schedule on the 200-cycle instance.
        resetB = 1'b0; startB = 1'b1; modeB = 2'd3;
        tick();
        check("hybB running", 32'(runB), 32'd1);
        for (int s = 0; s < 150; s++) begin
            cnt = 0; ticks = 0;
            for (int c = 1; c <= 200; c++) begin
                tick();
                cnt += int'(stepB);
                ticks += int'(tickB);
            end
            check($sformatf("hyb s%0d steps_last_sec", s), 32'(stepsB), 32'(expHybrid(s)));
            check($sformatf("hyb s%0d pulses", s), 32'(cnt), 32'(expHybrid(s)));
            check($sformatf("hyb s%0d tick/elapsed", s), {15'd0, tickB, elB},
                  {15'd0, 1'b1, 16'(s + 1)});
            if (ticks != 1) check($sformatf("hyb s%0d tick count", s), 32'(ticks), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/step_pulse_gen.md
# step_pulse_gen

Synthetic step source for the fitness-tracker datapath. It produces evenly spaced one-cycle step pulses at a rate selected by `mode`, plus a one-second timebase tick and the per-second step tally. Its outputs feed the step counter, distance, speed-check and high-activity stages, which sit downstream. Rates change only on second boundaries, so every completed second contains exactly the scheduled number of pulses.

## Interface
- `CLK_HZ`, default 100_000_000: clock cycles per second. The bench uses 1000.
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `reset` input, 1 bit: synchronous, active-high. It overrides every other input.
- `start` input, 1 bit: run enable, level-sensitive. Low means idle and cleared.
- `mode` input, 2 bits: 0 = walk (32 steps/s), 1 = jog (64 steps/s), 2 = run (128 steps/s), 3 = hybrid schedule.
- `step_pulse` output, 1 bit: one-cycle step strobe, registered.
- `sec_tick` output, 1 bit: one-cycle strobe at the end of each run second, registered.
- `steps_last_sec` output, 8 bits: pulse count of the last completed second.
- `elapsed_sec` output, 16 bits: completed seconds since RUN entry. Saturates at 65535.
- `running` output, 1 bit: high while in RUN.

## Operation
- **States:** IDLE and RUN.
  - IDLE to RUN when `start`=1.
  - RUN to IDLE when `start`=0.
  - Any state to IDLE when `reset`=1.
- **IDLE:**
  - Accumulator, cycle counter, second pulse tally, `elapsed_sec` and `steps_last_sec` are held at 0.
  - `step_pulse`, `sec_tick` and `running` are 0.
- **Rate latch (8 bits):**
  - Loaded from `mode` on the IDLE-to-RUN edge and on every `sec_tick` edge.
  - `mode` changes mid-second have no effect until the next second.
- **Hybrid rate,** indexed by `elapsed_sec` value s at load time:
  - s = 0..8: 20, 33, 66, 27, 70, 30, 19, 30, 33.
  - s = 9..72: 69.
  - s = 73..78: 34.
  - s = 79..143: 124.
  - s ≥ 144: 0.
- **Pulse generation,** using a 32-bit phase accumulator `acc`:
  - Each RUN cycle: t = acc + rate.
  - If t ≥ CLK_HZ: acc ← t − CLK_HZ and assert `step_pulse` on this edge.
  - Otherwise: acc ← t.
  - Rate 0 gives no pulses.
  - `rate` must be less than CLK_HZ; this is a parameter constraint checked by assertion.
- **Second boundary:**
  - The cycle counter counts 1..CLK_HZ. On the edge ending cycle CLK_HZ:
    - assert `sec_tick`;
    - `steps_last_sec` ← tally including any pulse issued on this same edge;
    - clear the tally;
    - `elapsed_sec` += 1, saturating;
    - reload the rate;
    - clear `acc` and the cycle counter.
  - With constant rate, `acc` is already 0 here, so the count is exact.
- **Tally width:** the tally is 8 bits and does not exceed 128, since the maximum rate is 128.

## Timing
- **Reset value of every output:** 0, visible after the first clock edge with `reset`=1.
- **RUN entry:** the first RUN cycle is the cycle after the edge that samples `start`=1. `running` rises on that edge.
- **Pulse n of a second:** `step_pulse` is high for the cycle after the edge ending RUN cycle ceil(n·CLK_HZ/rate), counted from 1 within the second.
- **Last pulse and tick coincide:** the last pulse (n = rate) falls on cycle CLK_HZ, so `step_pulse` and `sec_tick` are high together. That pulse counts toward the ending second.
- **Drop to IDLE:** `start` dropping mid-second discards the partial second. No `sec_tick` is issued and `steps_last_sec` is cleared on the next edge.
- **Mid-operation reset:** behaves identically to the drop to IDLE. `reset` and `start` high together give IDLE.
- **Re-entering RUN:** restarts the hybrid schedule from s = 0.

## Test plan
- Reset for 2 cycles with `start`=1: all outputs 0. Release: `running`=1 one edge later.
- CLK_HZ=1000, `mode`=0, run 3 s:
  - first `step_pulse` after RUN cycle 32;
  - 32 pulses per second;
  - `sec_tick` at cycle 1000, coincident with the 32nd pulse;
  - `steps_last_sec`=32 and `elapsed_sec`=1, 2, 3.
- `mode`=2: first pulse after cycle 8 (ceil(1000/128)).
  - Switch `mode` to 1 at cycle 500: second 0 still totals 128 and second 1 totals 64.
- `mode`=3, run 150 s:
  - `steps_last_sec` sequence 20, 33, 66, 27, 70, 30, 19, 30, 33, then 69 through s=72, 34 through s=78, 124 through s=143;
  - then 0 with no pulses while `sec_tick` continues.
- Drop `start` at cycle 700 of second 2, then raise it again:
  - no tick for the partial second;
  - outputs cleared;
  - the hybrid schedule restarts at 20.
- Hold `elapsed_sec` near saturation by forcing the counter to 65534: after two ticks it reads 65535 and stays there.
